// File: rtl/sram64_burst_reader_pkg.sv
// Shared types and constants for the 64-bit SRAM burst reader.
package sram64_burst_reader_pkg;

  localparam int ABITS_DEF  = 14;
  localparam int DBITS_DEF  = 64;
  localparam int LBITS_DEF  = 15;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sram64_burst_reader_if.sv
// Request, read-stream and SRAM read-port signals of the burst reader.
interface sram64_burst_reader_if
  import sram64_burst_reader_pkg::*;
#(
  parameter int ABITS = ABITS_DEF,
  parameter int DBITS = DBITS_DEF,
  parameter int LBITS = LBITS_DEF
);
  logic             req_valid;
  logic             req_ready;
  logic [ABITS-1:0] req_addr;
  logic [LBITS-1:0] req_len;
  logic             rd_valid;
  logic             rd_ready;
  logic [DBITS-1:0] rd_data;
  logic             rd_last;
  logic             done;
  logic             mem_ce;
  logic [ABITS-1:0] mem_a;
  logic [DBITS-1:0] mem_q;

  // Requester/consumer/SRAM side
  modport master (
    output req_valid, req_addr, req_len, rd_ready, mem_q,
    input  req_ready, rd_valid, rd_data, rd_last, done, mem_ce, mem_a
  );

  // Burst reader side
  modport slave (
    input  req_valid, req_addr, req_len, rd_ready, mem_q,
    output req_ready, rd_valid, rd_data, rd_last, done, mem_ce, mem_a
  );
endinterface

// File: rtl/sram64_rd_fifo.sv
// Two-entry FIFO of {last, data} that absorbs the SRAM read latency.
module sram64_rd_fifo
  import sram64_burst_reader_pkg::*;
#(
  parameter int DBITS = DBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             push_last,
  input  logic [DBITS-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             head_last,
  output logic [DBITS-1:0] head_data,
  output logic [1:0]       count
);
  logic [DBITS:0] store [FIFO_DEPTH];
  logic           wr_ptr;
  logic           rd_ptr;

  // pointer and occupancy update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // entry storage; contents are only visible through the gated head
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= {push_last, push_data};
  end

  assign valid = (count != 2'd0);
  // head reads as zero when empty so the stream outputs are clean after reset
  assign {head_last, head_data} = valid ? store[rd_ptr] : '0;

  overflow_check: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && count == 2'd2)) else $error("rd fifo overflow");
  underflow_check: assert property (@(posedge clk) disable iff (!rst)
    !(pop && !valid)) else $error("rd fifo underflow");
endmodule

// File: rtl/sram64_burst_reader.sv
// Burst read initiator: issues SRAM reads under a 2-word credit limit and
// streams the returned words with last-word marking and a done pulse.
module sram64_burst_reader
  import sram64_burst_reader_pkg::*;
#(
  parameter int ABITS = ABITS_DEF,
  parameter int DBITS = DBITS_DEF,
  parameter int LBITS = LBITS_DEF
) (
  input logic                  clk,
  input logic                  rst,
  sram64_burst_reader_if.slave bus
);
  state_t           state;
  state_t           state_nxt;
  logic [ABITS-1:0] addr;
  logic [LBITS-1:0] remaining;
  logic             vld_p1;
  logic             last_p1;
  logic             done_p1;
  logic [1:0]       fifo_count;
  logic             fifo_valid;
  logic             fifo_last;
  logic [DBITS-1:0] fifo_data;
  logic             accept;
  logic             pop;
  logic             credit;
  logic             ce;
  logic             ready;

  assign accept = bus.req_valid && ready;
  assign pop    = fifo_valid && bus.rd_ready;
  // fifo_count + inflight - pop < 2, rearranged to stay unsigned
  assign credit = ({1'b0, fifo_count} + {2'b00, vld_p1}) < (3'd2 + {2'b00, pop});

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && bus.req_len != '0) state_nxt = RUN;
      RUN:     if (ce && remaining == LBITS'(1)) state_nxt = DRAIN;
      DRAIN:   if (pop && fifo_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    ready = 1'b0;
    ce    = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RUN:     ce = (remaining != '0) && credit;
      default: ;
    endcase
  end

  // address/length counters, in-flight tag and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      remaining <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      // p0 -> p1: issued read is tagged in flight while the SRAM fetches it
      vld_p1  <= ce;
      last_p1 <= ce && (remaining == LBITS'(1));
      done_p1 <= (accept && bus.req_len == '0) ||
                 (state == DRAIN && pop && fifo_last);
      if (accept) begin
        addr      <= bus.req_addr;
        remaining <= bus.req_len;
      end else if (ce) begin
        addr      <= addr + ABITS'(1);
        remaining <= remaining - LBITS'(1);
      end
    end
  end

  // p1 -> fifo: SRAM output captured the cycle after its read enable
  sram64_rd_fifo #(.DBITS(DBITS)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_last (last_p1),
    .push_data (bus.mem_q),
    .pop       (pop),
    .valid     (fifo_valid),
    .head_last (fifo_last),
    .head_data (fifo_data),
    .count     (fifo_count)
  );

  assign bus.req_ready = ready;
  assign bus.mem_ce    = ce;
  assign bus.mem_a     = addr;
  assign bus.rd_valid  = fifo_valid;
  assign bus.rd_data   = fifo_data;
  assign bus.rd_last   = fifo_last;
  assign bus.done      = done_p1;
endmodule

// File: tb/tb_sram64_burst_reader.sv
// Scoreboard bench for sram64_burst_reader with a behavioural SRAM model.
module tb_sram64_burst_reader;
  import sram64_burst_reader_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   t0;
  int   n_vec;
  int   n_miss;

  sram64_burst_reader_if bus ();

  sram64_burst_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] word(input logic [13:0] a);
    return {16'hC0DE, 2'b00, a, 18'h0, a ^ 14'h2AAA};
  endfunction

  // behavioural SRAM read port: one-cycle latency
  always @(posedge clk) if (bus.mem_ce) bus.mem_q <= word(bus.mem_a);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [64:0]  exp_q [$];
  logic [13:0]  addr_q [$];

  // scoreboard monitor
  int          issued;
  int          popped;
  bit          mon_pop;
  bit          prev_stall;
  logic [63:0] prev_data;
  logic [64:0] ent;

  initial begin
    issued = 0; popped = 0; prev_stall = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        issued = 0; popped = 0; prev_stall = 0;
      end else begin
        mon_pop = bus.rd_valid && bus.rd_ready;
        if (prev_stall) begin
          check_val("hold_valid", bus.rd_valid, 1);
          check_val("hold_data", bus.rd_data, prev_data);
        end
        if (issued - popped - int'(mon_pop) >= 2)
          check_val("ce_no_credit", bus.mem_ce, 0);
        if (bus.mem_ce) begin
          check_val("outstanding", (issued - popped) <= 2, 1);
          if (addr_q.size() == 0) check_val("spurious_ce", bus.mem_ce, 0);
          else check_val("mem_a", bus.mem_a, addr_q.pop_front());
          issued++;
        end
        if (mon_pop) begin
          if (exp_q.size() == 0) check_val("spurious_rd", bus.rd_valid, 0);
          else begin
            ent = exp_q.pop_front();
            check_val("rd_data", bus.rd_data, ent[63:0]);
            check_val("rd_last", bus.rd_last, ent[64]);
          end
          popped++;
        end
        prev_stall = bus.rd_valid && !bus.rd_ready;
        prev_data  = bus.rd_data;
      end
    end
  end

  // per-run observations, written only by the stimulus process
  int first_ce, last_ce, ce_n, first_vld, vld_n, hs_n, last_n, last_at;
  int done_n, done_at, done2_at, accept_at;

  task automatic push_exp(input logic [13:0] a, input logic [14:0] n);
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back({(i == int'(n) - 1), word(a + 14'(i))});
      addr_q.push_back(a + 14'(i));
    end
  endtask

  task automatic start_req(input logic [13:0] a, input logic [14:0] n);
    @(posedge clk); #1;
    check_val("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = n;
    t0 = cyc;
    push_exp(a, n);
  endtask

  task automatic watch(input int n, input int pct, input bit hold);
    bit drop_next;
    int k;
    drop_next = !hold;
    first_ce = -1; last_ce = -1; ce_n = 0; first_vld = -1; vld_n = 0; hs_n = 0;
    last_n = 0; last_at = -1; done_n = 0; done_at = -1; done2_at = -1; accept_at = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (drop_next) bus.req_valid = 1'b0;
      bus.rd_ready = ($urandom_range(0, 99) < 32'(pct));
      @(negedge clk);
      k = cyc - t0;
      if (bus.mem_ce) begin
        if (first_ce < 0) first_ce = k;
        last_ce = k;
        ce_n++;
      end
      if (bus.rd_valid) begin
        if (first_vld < 0) first_vld = k;
        vld_n++;
        if (bus.rd_ready) begin
          hs_n++;
          if (bus.rd_last) begin
            last_n++;
            last_at = k;
          end
        end
      end
      if (bus.done) begin
        done_n++;
        if (done_n == 1) done_at = k;
        if (done_n == 2) done2_at = k;
      end
      if (hold && bus.req_valid && bus.req_ready && accept_at < 0) begin
        accept_at = k;
        drop_next = 1'b1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, bus.req_ready, 1);
    check_val({tag, "_rd_valid"}, bus.rd_valid, 0);
    check_val({tag, "_rd_last"}, bus.rd_last, 0);
    check_val({tag, "_rd_data"}, bus.rd_data, 0);
    check_val({tag, "_done"}, bus.done, 0);
    check_val({tag, "_mem_ce"}, bus.mem_ce, 0);
    check_val({tag, "_mem_a"}, bus.mem_a, 0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; t0 = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.rd_ready = 1'b0;

    // reset values
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    #2 rst = 1'b1;

    // basic 4-word burst, full throughput
    start_req(14'h0010, 15'd4);
    bus.rd_ready = 1'b1;
    watch(10, 100, 0);
    check_val("b4_first_ce", first_ce, 1);
    check_val("b4_last_ce", last_ce, 4);
    check_val("b4_ce_n", ce_n, 4);
    check_val("b4_first_vld", first_vld, 3);
    check_val("b4_vld_n", vld_n, 4);
    check_val("b4_last_at", last_at, 6);
    check_val("b4_last_n", last_n, 1);
    check_val("b4_done_at", done_at, 7);
    check_val("b4_done_n", done_n, 1);
    check_val("b4_q_empty", exp_q.size(), 0);

    // address wrap at top of SRAM
    start_req(14'h3FFE, 15'd4);
    watch(10, 100, 0);
    check_val("wrap_ce_n", ce_n, 4);
    check_val("wrap_done_n", done_n, 1);
    check_val("wrap_q_empty", exp_q.size(), 0);
    check_val("wrap_addr_empty", addr_q.size(), 0);

    // zero-length burst
    start_req(14'h0123, 15'd0);
    watch(5, 100, 0);
    check_val("len0_done_at", done_at, 1);
    check_val("len0_done_n", done_n, 1);
    check_val("len0_ce_n", ce_n, 0);
    check_val("len0_vld_n", vld_n, 0);

    // 16 words under random backpressure
    start_req(14'h0200, 15'd16);
    bus.rd_ready = 1'b0;
    watch(300, 30, 0);
    check_val("bp_hs_n", hs_n, 16);
    check_val("bp_ce_n", ce_n, 16);
    check_val("bp_last_n", last_n, 1);
    check_val("bp_done_n", done_n, 1);
    check_val("bp_q_empty", exp_q.size(), 0);

    // back-to-back requests with req_valid held
    start_req(14'h0100, 15'd3);
    @(posedge clk); #1;
    bus.rd_ready = 1'b1;
    bus.req_addr = 14'h0300;
    bus.req_len  = 15'd2;
    push_exp(14'h0300, 15'd2);
    watch(16, 100, 1);
    check_val("b2b_accept_at", accept_at, 6);
    check_val("b2b_done_at", done_at, 6);
    check_val("b2b_done2_at", done2_at, 11);
    check_val("b2b_done_n", done_n, 2);
    check_val("b2b_last_n", last_n, 2);
    check_val("b2b_hs_n", hs_n, 5);
    check_val("b2b_q_empty", exp_q.size(), 0);

    // reset in the middle of a burst
    start_req(14'h0040, 15'd8);
    bus.rd_ready = 1'b1;
    watch(3, 100, 0);
    check_val("mid_ce_before", bus.mem_ce, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    watch(6, 100, 0);
    check_val("post_vld_n", vld_n, 0);
    check_val("post_done_n", done_n, 0);
    check_val("post_ce_n", ce_n, 0);
    check_val("post_req_ready", bus.req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sram64_burst_reader.md
# sram64_burst_reader

Burst read initiator for the 64-bit banked SRAM wrappers. It accepts a (base address, length) request, drives the wrapper's read port (CE1/A1, one-cycle Q1 latency), and delivers the words on a valid/ready stream with last-word marking. A credit-limited 2-entry buffer absorbs the fixed read latency, so the stream sustains one word per cycle and tolerates arbitrary backpressure without losing data.

## Interface
- ABITS, 14, SRAM word-address width
- DBITS, 64, data width
- LBITS, 15, burst length width (max 16384 words)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  burst request valid
- req_ready  out  1  block idle, request can be accepted
- req_addr  in  ABITS  first word address
- req_len  in  LBITS  word count; 0 is legal (no-op burst)
- rd_valid  out  1  output word valid
- rd_ready  in  1  consumer accepts word
- rd_data  out  DBITS  output word
- rd_last  out  1  marks final word of burst, qualified by rd_valid
- done  out  1  one-cycle pulse at burst completion
- mem_ce  out  1  to wrapper CE1
- mem_a  out  ABITS  to wrapper A1
- mem_q  in  DBITS  from wrapper Q1, valid the cycle after mem_ce

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: req_ready=1. On req_valid&&req_ready latch addr, remaining=req_len. len=0 -> pulse done next cycle, stay IDLE, no mem_ce. Otherwise -> RUN.
- RUN: req_ready=0. mem_ce=1 when remaining>0 and credit available; mem_a = address register. Each issue: addr+=1 mod 2^ABITS (0x3FFF -> 0x0000), remaining-=1, inflight=1 next cycle with last flag = (remaining==1). Issue of final word -> DRAIN.
- Credit: issue allowed iff fifo_count + inflight - pop < 2, pop = rd_valid&&rd_ready (combinational on rd_ready).
- Capture: inflight word taken from mem_q into the FIFO at the end of the cycle after its mem_ce, together with its last flag. FIFO never overflows by construction; overflow is an assertion failure.
- DRAIN: no issue; when the last-flagged word handshakes, pulse done next cycle and return to IDLE (req_ready=1 in the done cycle).
- rd_data/rd_last come from FIFO head; rd_valid = FIFO not empty. rd_data is held stable while rd_valid&&!rd_ready.
- mem_ce never asserted outside RUN; no write-port signals driven.
- Reset (any time, including mid-burst): state=IDLE, FIFO empty, inflight=0, counters=0. Outputs: req_ready=1, rd_valid=0, rd_last=0, rd_data=0, done=0, mem_ce=0, mem_a=0. Partially delivered burst is discarded; no done pulse.

## Timing
- Request accepted at cycle t -> first mem_ce at t+1, mem_q at t+2, rd_valid at t+3.
- Steady state with rd_ready=1: one mem_ce and one rd handshake per cycle; N-word burst: mem_ce t+1..t+N, rd_valid t+3..t+N+2, done t+N+3, next request accepted at t+N+3 earliest.
- With rd_ready=0: at most 2 words outstanding (FIFO + inflight); mem_ce drops until a pop frees credit, issue resumes same cycle as pop.
- len=0: done at t+1.

## Structure
- Shared package: FSM state enum, FIFO depth constant (2), default ABITS/DBITS/LBITS.
- One sub-module: sram64_rd_fifo, 2-entry synchronous FIFO of {last, data} with count output, async active-low reset.

## Test plan
- Reset asserted mid-RUN -> all outputs at reset values immediately; after release req_ready=1, no stale rd_valid or done.
- addr 0x0010, len 4, rd_ready=1 -> mem_a 0x10..0x13 at t+1..t+4, rd_valid t+3..t+6 with SRAM contents in order, rd_last at t+6 only, done at t+7.
- addr 0x3FFE, len 4 -> mem_a 0x3FFE, 0x3FFF, 0x0000, 0x0001; data matches those locations.
- len 0 -> done at t+1, mem_ce never asserted, rd_valid stays 0.
- len 16, rd_ready random 30% duty -> all 16 words delivered in order, never more than 2 outstanding, mem_ce=0 whenever credit exhausted, single done.
- Back-to-back requests (len 3 then len 2, req_valid held) -> second accepted in the done cycle of the first; rd_last once per burst, two done pulses.
